// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline interlock/forwarding scheduler.
// Holds the forwarding select encodings, the stage-shadow record and the select priority rule.
package pipe_hazard_ctrl_pkg;

    localparam int RA_W_DEF = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EALU = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MMEM = 2'b11;

    typedef struct packed {
        logic                wreg;
        logic                m2reg;
        logic [RA_W_DEF-1:0] rn;
    } shadow_t;

    // EX beats MEM; a load still in EX has no data yet, so it never forwards.
    function automatic logic [1:0] fwd_sel(input logic e_hit, input logic e_m2reg,
                                           input logic m_hit, input logic m_m2reg);
        if (e_hit && !e_m2reg)      return FWD_EALU;
        else if (m_hit && !m_m2reg) return FWD_MALU;
        else if (m_hit && m_m2reg)  return FWD_MMEM;
        else                        return FWD_NONE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != '1)) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use interlock, branch flush and operand-forwarding scheduler for the 5-stage pipeline.
// Tracks EX/MEM destination info in its own shadow registers; the shadow record is sized by RA_W_DEF.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RA_W  = RA_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             hold,
    input  logic [RA_W-1:0]  d_rs,
    input  logic [RA_W-1:0]  d_rt,
    input  logic [RA_W-1:0]  d_rn,
    input  logic             d_wreg,
    input  logic             d_m2reg,
    input  logic             d_users,
    input  logic             d_usert,
    input  logic             jwait,
    output logic             wpcir,
    output logic             de_bubble,
    output logic             if_flush,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    shadow_t e_q, e_d;
    shadow_t m_q, m_d;

    logic e_valid, m_valid;
    logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
    logic lu;

    always_comb begin
        e_valid  = e_q.wreg && (e_q.rn != '0);
        m_valid  = m_q.wreg && (m_q.rn != '0);
        e_hit_rs = e_valid && (e_q.rn == d_rs);
        e_hit_rt = e_valid && (e_q.rn == d_rt);
        m_hit_rs = m_valid && (m_q.rn == d_rs);
        m_hit_rt = m_valid && (m_q.rn == d_rt);

        lu = e_q.m2reg && ((d_users && e_hit_rs) || (d_usert && e_hit_rt));

        wpcir     = !hold && !lu;
        de_bubble = lu && !hold;
        if_flush  = jwait && !lu && !hold;

        fwda = fwd_sel(e_hit_rs, e_q.m2reg, m_hit_rs, m_q.m2reg);
        fwdb = fwd_sel(e_hit_rt, e_q.m2reg, m_hit_rt, m_q.m2reg);
    end

    // A stalled ID instruction enters EX as a bubble so it can re-issue next cycle.
    always_comb begin
        e_d = e_q;
        m_d = m_q;
        if (!hold) begin
            m_d = e_q;
            if (lu) begin
                e_d = '0;
            end else begin
                e_d.wreg  = d_wreg;
                e_d.m2reg = d_m2reg;
                e_d.rn    = d_rn;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e_q <= '0;
            m_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (de_bubble),
        .value  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (if_flush),
        .value  (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use stall, flush, hold and counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int RA_W  = 5;
    localparam int CNT_W = 4;

    logic             clock;
    logic             resetn;
    logic             hold;
    logic [RA_W-1:0]  d_rs, d_rt, d_rn;
    logic             d_wreg, d_m2reg, d_users, d_usert, jwait;
    logic             wpcir, de_bubble, if_flush;
    logic [1:0]       fwda, fwdb;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .hold      (hold),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_rn      (d_rn),
        .d_wreg    (d_wreg),
        .d_m2reg   (d_m2reg),
        .d_users   (d_users),
        .d_usert   (d_usert),
        .jwait     (jwait),
        .wpcir     (wpcir),
        .de_bubble (de_bubble),
        .if_flush  (if_flush),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one edge and settle just past it, so inputs change away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                          input logic [RA_W-1:0] rn, input logic wreg, input logic m2reg,
                          input logic users, input logic usert, input logic jw);
        d_rs = rs; d_rt = rt; d_rn = rn;
        d_wreg = wreg; d_m2reg = m2reg;
        d_users = users; d_usert = usert; jwait = jw;
        #2;
    endtask

    task automatic do_reset();
        hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        set_id(0, 0, 7, 1, 0, 0, 0, 0);
        tick();
        set_id(0, 0, 4, 1, 1, 0, 0, 0);
        tick();
        set_id(1, 2, 9, 1, 0, 0, 0, 0);
        tick();
        // EX = r9 add, MEM = r4 load; r9 reads with the load would forward.
        set_id(9, 4, 0, 0, 0, 1, 1, 1);
        total++;
        if (fwda !== 2'b01) begin bad++; $display("[TB] FAIL pre_reset_fwda got=%b exp=01", fwda); end
        resetn = 1'b0;
        #1;
        total++;
        if (wpcir !== 1'b1 || de_bubble !== 1'b0 || if_flush !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_ctrl got=%b%b%b exp=101", wpcir, de_bubble, if_flush);
        end
        total++;
        if (fwda !== 2'b00 || fwdb !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_fwd got=%b/%b exp=00/00", fwda, fwdb);
        end
        total++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            bad++; $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        jwait = 1'b0;
        #1;
        resetn = 1'b1;
        set_id(5, 5, 0, 0, 0, 1, 1, 0);
        total++;
        if (fwda !== 2'b00 || wpcir !== 1'b1 || if_flush !== 1'b0) begin
            bad++; $display("[TB] FAIL post_reset got=%b/%b/%b exp=00/1/0", fwda, wpcir, if_flush);
        end
        tick();
    endtask

    task automatic test_forwarding();
        do_reset();
        set_id(0, 0, 3, 1, 0, 0, 0, 0);
        tick();
        set_id(3, 0, 8, 1, 0, 1, 1, 0);
        total++;
        if (fwda !== 2'b01) begin bad++; $display("[TB] FAIL fwd_ex got=%b exp=01", fwda); end
        tick();
        set_id(3, 8, 0, 0, 0, 1, 1, 0);
        total++;
        if (fwda !== 2'b10) begin bad++; $display("[TB] FAIL fwd_mem got=%b exp=10", fwda); end
        total++;
        if (fwdb !== 2'b01) begin bad++; $display("[TB] FAIL fwdb_ex got=%b exp=01", fwdb); end
        tick();
        set_id(0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 1, 1, 0);
        total++;
        if (fwda !== 2'b00 || fwdb !== 2'b00) begin
            bad++; $display("[TB] FAIL fwd_r0 got=%b/%b exp=00/00", fwda, fwdb);
        end
        tick();
        set_id(0, 0, 5, 1, 0, 0, 0, 0);
        tick();
        set_id(0, 0, 5, 1, 0, 0, 0, 0);
        tick();
        set_id(5, 6, 0, 0, 0, 0, 0, 0);
        total++;
        if (fwda !== 2'b01) begin bad++; $display("[TB] FAIL fwd_ex_prio got=%b exp=01", fwda); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(0, 0, 4, 1, 1, 0, 0, 0);
        tick();
        set_id(1, 4, 9, 1, 0, 0, 1, 0);
        total++;
        if (wpcir !== 1'b0 || de_bubble !== 1'b1) begin
            bad++; $display("[TB] FAIL lu_stall got=%b%b exp=01", wpcir, de_bubble);
        end
        total++;
        if (fwdb !== 2'b00) begin bad++; $display("[TB] FAIL lu_fwdb_ex got=%b exp=00", fwdb); end
        tick();
        #2;
        total++;
        if (stall_cnt !== 4'd1) begin bad++; $display("[TB] FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        total++;
        if (wpcir !== 1'b1 || de_bubble !== 1'b0 || fwdb !== 2'b11) begin
            bad++; $display("[TB] FAIL lu_release got=%b%b/%b exp=10/11", wpcir, de_bubble, fwdb);
        end
        tick();
        set_id(0, 0, 4, 1, 1, 0, 0, 0);
        tick();
        set_id(4, 4, 0, 0, 0, 0, 0, 0);
        total++;
        if (wpcir !== 1'b1 || de_bubble !== 1'b0 || fwdb !== 2'b00) begin
            bad++; $display("[TB] FAIL lu_unused got=%b%b/%b exp=10/00", wpcir, de_bubble, fwdb);
        end
        tick();
        total++;
        if (stall_cnt !== 4'd1) begin bad++; $display("[TB] FAIL lu_cnt_kept got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_branch_stall();
        do_reset();
        set_id(0, 0, 6, 1, 1, 0, 0, 0);
        tick();
        set_id(6, 0, 0, 0, 0, 1, 0, 1);
        total++;
        if (if_flush !== 1'b0 || de_bubble !== 1'b1) begin
            bad++; $display("[TB] FAIL br_stall got=%b%b exp=01", if_flush, de_bubble);
        end
        tick();
        #2;
        total++;
        if (if_flush !== 1'b1 || wpcir !== 1'b1 || fwda !== 2'b11) begin
            bad++; $display("[TB] FAIL br_flush got=%b%b/%b exp=11/11", if_flush, wpcir, fwda);
        end
        total++;
        if (flush_cnt !== 4'd0) begin bad++; $display("[TB] FAIL br_cnt_pre got=%0d exp=0", flush_cnt); end
        tick();
        total++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
            bad++; $display("[TB] FAIL br_cnt got=%0d/%0d exp=1/1", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_hold();
        do_reset();
        set_id(0, 0, 2, 1, 0, 0, 0, 0);
        tick();
        hold = 1'b1;
        set_id(2, 11, 11, 1, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wpcir !== 1'b0 || if_flush !== 1'b0 || fwda !== 2'b01 || fwdb !== 2'b00) begin
                bad++; $display("[TB] FAIL hold_cycle%0d got=%b%b/%b/%b exp=00/01/00", i, wpcir, if_flush, fwda, fwdb);
            end
            tick();
            #2;
        end
        total++;
        if (flush_cnt !== 4'd0) begin bad++; $display("[TB] FAIL hold_cnt got=%0d exp=0", flush_cnt); end
        hold = 1'b0;
        jwait = 1'b0;
        #1;
        total++;
        if (wpcir !== 1'b1 || fwda !== 2'b01) begin
            bad++; $display("[TB] FAIL hold_release got=%b/%b exp=1/01", wpcir, fwda);
        end
        tick();
        set_id(2, 11, 0, 0, 0, 1, 1, 0);
        total++;
        if (fwda !== 2'b10 || fwdb !== 2'b01) begin
            bad++; $display("[TB] FAIL hold_resume got=%b/%b exp=10/01", fwda, fwdb);
        end
        tick();
        do_reset();
        set_id(0, 0, 4, 1, 1, 0, 0, 0);
        tick();
        hold = 1'b1;
        set_id(0, 4, 0, 0, 0, 0, 1, 0);
        total++;
        if (de_bubble !== 1'b0 || wpcir !== 1'b0) begin
            bad++; $display("[TB] FAIL hold_lu got=%b%b exp=00", de_bubble, wpcir);
        end
        tick();
        total++;
        if (stall_cnt !== 4'd0) begin bad++; $display("[TB] FAIL hold_lu_cnt got=%0d exp=0", stall_cnt); end
        hold = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        // A load that reads its own target stalls every other cycle: 2, 4, 6, ...
        set_id(4, 0, 4, 1, 1, 1, 0, 0);
        for (int i = 1; i <= 28; i++) tick();
        total++;
        if (stall_cnt !== 4'd14) begin bad++; $display("[TB] FAIL sat_mid got=%0d exp=14", stall_cnt); end
        for (int i = 29; i <= 41; i++) tick();
        total++;
        if (stall_cnt !== 4'd15) begin bad++; $display("[TB] FAIL sat_top got=%0d exp=15", stall_cnt); end
    endtask

    initial begin
        resetn = 1'b0;
        hold   = 1'b0;
        d_rs = '0; d_rt = '0; d_rn = '0;
        d_wreg = 1'b0; d_m2reg = 1'b0; d_users = 1'b0; d_usert = 1'b0; jwait = 1'b0;
        #7;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_stall();
        test_hold();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
